// File: rtl/loader_pkg.sv
// Helpers and drain-FSM state codes for the page loader.
package loader_pkg;
  function automatic int clog2_len(input int page_bytes);
    return $clog2(page_bytes + 1);
  endfunction

  // IDLE and DONE both present NONE on cmd, so the FSM keeps its own codes.
  localparam logic [2:0] ST_ERASE = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_END   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/spi_pkg.sv
// Command vocabulary shared with the spi flash controller.
package spi_pkg;
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ERASE = 2'd1,
    WRITE = 2'd2,
    END   = 2'd3
  } cmd_t;
endpackage

// File: rtl/page_loader_ram.sv
// Simple dual-port RAM holding all page buffers: sync write, registered read.
module page_ram #(
  parameter int ADDR_SIZE = 9,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/page_loader.sv
// Stages a UART byte stream into a ring of page buffers and sequences the spi
// flash controller through ERASE, one WRITE per page, then END.
module page_loader
  import spi_pkg::*;
  import loader_pkg::*;
#(
  parameter int          PAGE_BYTES = 256,
  parameter int          NUM_BUFS   = 2,
  parameter logic [23:0] BASE_ADDR  = 24'h0
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                in_valid,
  input  logic [7:0]                          in_data,
  input  logic                                in_timeout,
  output logic                                in_ready,
  output logic                                overflow,
  output cmd_t                                cmd,
  input  logic                                cmd_done,
  output logic [23:0]                         addr_out,
  output logic [clog2_len(PAGE_BYTES)-1:0]    page_len,
  input  logic [$clog2(PAGE_BYTES)-1:0]       rd_addr,
  output logic [7:0]                          rd_data,
  output logic                                done
);
  localparam int OFF_W = $clog2(PAGE_BYTES);
  localparam int BUF_W = $clog2(NUM_BUFS);
  localparam int LEN_W = clog2_len(PAGE_BYTES);
  localparam int CNT_W = $clog2(NUM_BUFS + 1);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(PAGE_BYTES);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(NUM_BUFS);
  localparam logic [23:0]      PAGE_STEP = 24'(PAGE_BYTES);

  logic [2:0]       state;
  logic [BUF_W-1:0] wr_buf;
  logic [BUF_W-1:0] rd_buf;
  logic [LEN_W-1:0] fill;
  logic [CNT_W-1:0] count;
  logic             seen_data;
  logic             end_req;
  logic [LEN_W-1:0] len_rf [NUM_BUFS];

  logic             active;
  logic             accept;
  logic [LEN_W-1:0] fill_inc;
  logic             full_commit;
  logic             part_commit;
  logic             commit;
  logic             pg_release;

  // A byte arriving with the timeout is counted before the flush decision.
  always_comb begin
    active      = (state != ST_DONE);
    in_ready    = (count < MAX_CNT);
    accept      = in_valid && in_ready && active;
    fill_inc    = fill + LEN_W'(accept);
    full_commit = accept && (fill_inc == FULL_LEN);
    part_commit = in_timeout && active && !full_commit && (fill_inc != '0);
    commit      = full_commit || part_commit;
    pg_release  = (state == ST_WRITE) && cmd_done;
  end

  always_comb begin
    cmd = NONE;
    case (state)
      ST_ERASE: cmd = ERASE;
      ST_WRITE: cmd = WRITE;
      ST_END:   cmd = END;
      default:  cmd = NONE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_ERASE;
      wr_buf    <= '0;
      rd_buf    <= '0;
      fill      <= '0;
      count     <= '0;
      seen_data <= 1'b0;
      end_req   <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      addr_out  <= BASE_ADDR;
      page_len  <= FULL_LEN;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (accept) seen_data <= 1'b1;
      if (in_timeout && active && (seen_data || accept)) end_req <= 1'b1;
      fill <= commit ? '0 : fill_inc;
      if (commit) wr_buf <= wr_buf + BUF_W'(1);
      if (pg_release) begin
        rd_buf   <= rd_buf + BUF_W'(1);
        addr_out <= addr_out + PAGE_STEP;
      end
      count <= count + CNT_W'(commit) - CNT_W'(pg_release);

      case (state)
        ST_ERASE: if (cmd_done) state <= ST_IDLE;
        ST_IDLE: begin
          if (count != '0) begin
            state    <= ST_WRITE;
            page_len <= len_rf[rd_buf];
          end else if (end_req) begin
            state <= ST_END;
          end
        end
        ST_WRITE: if (cmd_done) state <= ST_IDLE;
        ST_END: begin
          if (cmd_done) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) len_rf[wr_buf] <= fill_inc;
  end

  page_ram #(
    .ADDR_SIZE(OFF_W + BUF_W),
    .DATA_SIZE(8)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr({wr_buf, fill[OFF_W-1:0]}),
    .wdata(in_data),
    .raddr({rd_buf, rd_addr}),
    .rdata(rd_data)
  );

  assert property (@(posedge clk) disable iff (!n_rst) count <= MAX_CNT);
  assert property (@(posedge clk) disable iff (!n_rst) !(pg_release && !commit && count == '0));
endmodule
